// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmitter among NREQ byte producers.
// Define UART_ARB_TIMEOUT_EN to add the SEND-state watchdog that drives tx_err_o.
module uart_tx_arbiter #(
  parameter int NREQ           = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [NREQ-1:0]   req_i,
  input  logic [8*NREQ-1:0] req_data_i,
  output logic [NREQ-1:0]   ack_o,
  output logic              tx_en_o,
  output logic [7:0]        tx_data_o,
  input  logic              tx_done_i,
  output logic              busy_o,
  output logic [2:0]        grant_idx_o,
  output logic [15:0]       tx_count_o,
  output logic              tx_err_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'(NREQ - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t            state_q, state_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [2:0]        grant_idx_q, grant_idx_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [15:0]       tx_count_q, tx_count_d;
  logic [7:0]        gap_q, gap_d;
  logic              tx_done_q;

  logic [7:0]        req_byte [NREQ];
  logic [NREQ-1:0]   req_hi;
  logic [NREQ-1:0]   grant_oh;
  logic [2:0]        hi_sel, lo_sel, grant_sel;
  logic [7:0]        grant_data;
  logic              done_evt;
  logic              byte_end;

`ifdef UART_ARB_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0]       to_q, to_d;
  logic              tx_err_q, tx_err_d;
  logic              to_hit;
`endif

  // req_hi keeps only requesters at or above the pointer, so they win before wrapping.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign req_byte[gi] = req_data_i[8*gi +: 8];
      assign req_hi[gi]   = req_i[gi] && (3'(gi) >= ptr_q);
      assign grant_oh[gi] = (grant_idx_q == 3'(gi));
    end
  endgenerate

  always_comb begin
    hi_sel = '0;
    lo_sel = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_hi[i]) hi_sel = 3'(i);
      if (req_i[i])  lo_sel = 3'(i);
    end
    grant_sel  = (|req_hi) ? hi_sel : lo_sel;
    grant_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_sel == 3'(i)) grant_data = req_byte[i];
    end
  end

  // A held-high tx_done_i must fall and rise again before it completes another byte.
  assign done_evt = tx_done_i && !tx_done_q;

`ifdef UART_ARB_TIMEOUT_EN
  assign to_hit   = (to_q == TO_LAST);
  assign byte_end = done_evt || to_hit;
`else
  assign byte_end = done_evt;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_idx_d = grant_idx_q;
    tx_data_d   = tx_data_q;
    ack_d       = '0;
    tx_count_d  = tx_count_q;
    gap_d       = gap_q;
`ifdef UART_ARB_TIMEOUT_EN
    to_d        = to_q;
    tx_err_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          state_d     = S_SEND;
          grant_idx_d = grant_sel;
          tx_data_d   = grant_data;
`ifdef UART_ARB_TIMEOUT_EN
          to_d        = '0;
`endif
        end
      end
      S_SEND: begin
`ifdef UART_ARB_TIMEOUT_EN
        to_d = to_q + 32'd1;
`endif
        if (byte_end) begin
          state_d = S_GAP;
          gap_d   = '0;
          ack_d   = grant_oh;
          ptr_d   = (grant_idx_q == LAST_IDX) ? 3'd0 : grant_idx_q + 3'd1;
          if (done_evt) begin
            tx_count_d = tx_count_q + 16'd1;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else begin
            tx_err_d = 1'b1;
          end
`endif
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      grant_idx_q <= '0;
      tx_data_q   <= '0;
      ack_q       <= '0;
      tx_count_q  <= '0;
      gap_q       <= '0;
      tx_done_q   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      to_q        <= '0;
      tx_err_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_idx_q <= grant_idx_d;
      tx_data_q   <= tx_data_d;
      ack_q       <= ack_d;
      tx_count_q  <= tx_count_d;
      gap_q       <= gap_d;
      tx_done_q   <= tx_done_i;
`ifdef UART_ARB_TIMEOUT_EN
      to_q        <= to_d;
      tx_err_q    <= tx_err_d;
`endif
    end
  end

  assign tx_en_o     = (state_q == S_SEND);
  assign busy_o      = (state_q != S_IDLE);
  assign tx_data_o   = tx_data_q;
  assign ack_o       = ack_q;
  assign grant_idx_o = grant_idx_q;
  assign tx_count_o  = tx_count_q;
`ifdef UART_ARB_TIMEOUT_EN
  assign tx_err_o    = tx_err_q;
`else
  assign tx_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a round-robin queue model predicts grant order,
// a negedge monitor checks each byte presented to the UART against it.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int GAP  = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   ack;
  logic              tx_en;
  logic [7:0]        tx_data;
  logic              tx_done;
  logic              busy;
  logic [2:0]        grant_idx;
  logic [15:0]       tx_count;
  logic              tx_err;

  uart_tx_arbiter #(
    .NREQ(NREQ),
    .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(100000)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .req_i(req),
    .req_data_i(req_data),
    .ack_o(ack),
    .tx_en_o(tx_en),
    .tx_data_o(tx_data),
    .tx_done_i(tx_done),
    .busy_o(busy),
    .grant_idx_o(grant_idx),
    .tx_count_o(tx_count),
    .tx_err_o(tx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  int         compared   = 0;
  int         mismatched = 0;
  int         served     = 0;
  int         ptr_m      = 0;
  bit         mode_auto  = 1'b1;

  // Per-requester byte lists; head advances when that requester sees its Ack.
  logic [7:0] rq_buf [NREQ][8];
  int         rq_head [NREQ];
  int         rq_len  [NREQ];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NREQ; i++) begin
      if (rq_head[i] < rq_len[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Reference: serve the first pending requester at or after the pointer, then move past it.
  task automatic plan();
    int rem [NREQ];
    int pos [NREQ];
    int left;
    exp_t e;
    left = 0;
    for (int i = 0; i < NREQ; i++) begin
      pos[i] = rq_head[i];
      rem[i] = rq_len[i] - rq_head[i];
      left  += rem[i];
    end
    while (left > 0) begin
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (ptr_m + k) % NREQ;
        if (rem[c] > 0) begin
          e.idx  = c;
          e.data = rq_buf[c][pos[c]];
          exp_q.push_back(e);
          pos[c]++;
          rem[c]--;
          left--;
          served++;
          ptr_m = (c + 1) % NREQ;
          break;
        end
      end
    end
  endtask

  task automatic load(input int idx, input int n, input logic [7:0] b0, input logic [7:0] b1);
    rq_head[idx] = 0;
    rq_len[idx]  = n;
    rq_buf[idx][0] = b0;
    rq_buf[idx][1] = b1;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #3;
      if (all_empty() && !busy && !tx_en) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_reached", 32'(ok), 32'd1);
    if (ok) check("tx_count_total", {16'd0, tx_count}, 32'(served));
  endtask

  task automatic wait_tx_en();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #3;
      if (tx_en) begin
        ok = 1'b1;
        break;
      end
    end
    check("tx_en_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_ack();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #3;
      if (ack != '0) begin
        ok = 1'b1;
        break;
      end
    end
    check("ack_seen", 32'(ok), 32'd1);
  endtask

  // Requester model: hold Req with stable data until Ack, then present the next byte.
  initial begin
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i] && rq_head[i] < rq_len[i]) rq_head[i]++;
        req[i] = (rq_head[i] < rq_len[i]);
        req_data[8*i +: 8] = (rq_head[i] < rq_len[i] && rq_head[i] < 8) ? rq_buf[i][rq_head[i]] : 8'h00;
      end
    end
  end

  // UART model: after TxEn rises, pulse TxDone after a random delay.
  initial begin
    tx_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (mode_auto && tx_en && rst_n) begin
        repeat ($urandom_range(1, 20)) @(posedge clk);
        #1;
        if (mode_auto) tx_done = 1'b1;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
        if (mode_auto) tx_done = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on each new byte and checks the handshake rules.
  int         cur_idx  = 0;
  logic [7:0] cur_data = 8'h00;
  logic       prev_en  = 1'b0;
  logic [NREQ-1:0] prev_ack = '0;
  int         low_run  = 0;
  bit         had_byte = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_en  = 1'b0;
      prev_ack = '0;
      low_run  = 0;
      had_byte = 1'b0;
    end else begin
      if (tx_en && !prev_en) begin
        check("pending_expectation", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("grant_idx", 32'(grant_idx), 32'(e.idx));
          check("tx_data", 32'(tx_data), 32'(e.data));
          cur_idx  = e.idx;
          cur_data = e.data;
          $display("byte: requester %0d data %02h (t=%0t)", grant_idx, tx_data, $time);
        end
        if (had_byte) check("gap_low_cycles", 32'(low_run >= GAP), 32'd1);
        check("busy_in_send", 32'(busy), 32'd1);
        low_run = 0;
      end else if (tx_en) begin
        check("tx_data_stable", 32'(tx_data), 32'(cur_data));
      end
      if (ack != '0) begin
        check("ack_grantee", 32'(ack), 32'(1 << cur_idx));
        check("ack_single_cycle", 32'(prev_ack), 32'd0);
        check("tx_en_low_at_ack", 32'(tx_en), 32'd0);
        check("tx_err_idle", 32'(tx_err), 32'd0);
        had_byte = 1'b1;
      end
      if (!tx_en) low_run++;
      prev_en  = tx_en;
      prev_ack = ack;
    end
  end

  initial begin
    rst_n    = 1'b0;
    req      = '0;
    req_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      rq_head[i] = 0;
      rq_len[i]  = 0;
    end
    #12;
    check("rst_tx_en", 32'(tx_en), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant_idx", 32'(grant_idx), 32'd0);
    check("rst_tx_count", 32'(tx_count), 32'd0);
    check("rst_tx_err", 32'(tx_err), 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;

    // Single requester, with the one-cycle request-to-TxEn latency checked.
    @(posedge clk); #2;
    load(0, 1, 8'h41, 8'h00);
    plan();
    @(posedge clk); #3;
    check("latency_req_cycle", 32'(tx_en), 32'd0);
    @(posedge clk); #3;
    check("latency_next_cycle", 32'(tx_en), 32'd1);
    wait_idle();

    // Round-robin from a fresh pointer with all four requesting.
    rst_n = 1'b0; served = 0; ptr_m = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #2;
    load(0, 2, 8'h10, 8'h10);
    load(1, 1, 8'h11, 8'h00);
    load(2, 1, 8'h12, 8'h00);
    load(3, 1, 8'h13, 8'h00);
    plan();
    wait_idle();

    // Pointer wrap: serve 3, then 0 and 3 together must give 0 first.
    @(posedge clk); #2;
    load(3, 1, 8'h33, 8'h00);
    plan();
    wait_idle();
    @(posedge clk); #2;
    load(0, 1, 8'hA0, 8'h00);
    load(3, 1, 8'hA3, 8'h00);
    plan();
    wait_idle();

    // Randomized batches.
    for (int it = 0; it < 12; it++) begin
      @(posedge clk); #2;
      for (int i = 0; i < NREQ; i++) begin
        rq_head[i] = 0;
        rq_len[i]  = $urandom_range(0, 3);
        for (int b = 0; b < 3; b++) rq_buf[i][b] = 8'($urandom);
      end
      plan();
      wait_idle();
    end

    // Reset in the middle of SEND: TxEn drops at once, no Ack, request re-granted.
    mode_auto = 1'b0;
    @(posedge clk); #2;
    load(2, 1, 8'h52, 8'h00);
    plan();
    wait_tx_en();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_tx_en", 32'(tx_en), 32'd0);
    check("midrst_ack", 32'(ack), 32'd0);
    check("midrst_tx_count", 32'(tx_count), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_grant_idx", 32'(grant_idx), 32'd0);
    served = 0;
    ptr_m  = 0;
    plan();
    mode_auto = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    wait_idle();

    // TxDone stuck high across two bytes: the second needs a fresh rising edge.
    mode_auto = 1'b0;
    @(posedge clk); #2;
    load(1, 2, 8'h61, 8'h62);
    plan();
    wait_tx_en();
    repeat (3) @(posedge clk);
    #3 tx_done = 1'b1;
    wait_ack();
    wait_tx_en();
    repeat (20) @(posedge clk);
    #3;
    check("stuck_tx_en_held", 32'(tx_en), 32'd1);
    check("stuck_tx_count", 32'(tx_count), 32'(served - 1));
    tx_done = 1'b0;
    @(posedge clk); #3;
    tx_done = 1'b1;
    wait_ack();
    tx_done = 1'b0;
    mode_auto = 1'b1;
    wait_idle();

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
